// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types; 32-bit word, BTB entry and its 2-bit saturating counter.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [1:0] bcnt_t;
  localparam bcnt_t BCNT_RST = 2'b01;
  localparam bcnt_t BCNT_ALLOC = 2'b10;
  // tag is kept full-width; only pc[31:IDX+2] is ever stored, upper bits stay zero
  typedef struct packed {
    logic  valid;
    word_t tag;
    word_t target;
    bcnt_t counter;
  } btb_entry_t;
  function automatic bcnt_t bcnt_step(bcnt_t c, logic taken);
    return taken ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer with combinational lookup and registered update.
//   clk_i, rst_ni       clock, async active-low reset (clears valid, counters to 2'b01)
//   lookup_pc_i         fetch PC to look up
//   hit_o, target_o     predicted-taken flag and stored target for lookup_pc_i
//   upd_*_i             resolved control transfer used to train the buffer
module btb
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  word_t lookup_pc_i,
  output logic  hit_o,
  output word_t target_o,
  input  logic  upd_valid_i,
  input  word_t upd_pc_i,
  input  logic  upd_taken_i,
  input  word_t upd_target_i
);
  localparam int IDX = $clog2(DEPTH);
  btb_entry_t mem_q [DEPTH];
  btb_entry_t lk_e, up_e, ent_d;
  logic wr_d, up_hit;
  logic [IDX-1:0] l_idx, u_idx;
  function automatic word_t tag_of(word_t pc);
    return pc >> (IDX + 2);
  endfunction
  assign l_idx = lookup_pc_i[IDX+1:2];
  assign u_idx = upd_pc_i[IDX+1:2];
  // lookup reads the registered array, so a same-cycle update is seen only next cycle
  assign lk_e = mem_q[l_idx];
  assign hit_o = lk_e.valid && lk_e.tag == tag_of(lookup_pc_i) && lk_e.counter[1];
  assign target_o = lk_e.target;
  assign up_e = mem_q[u_idx];
  assign up_hit = up_e.valid && up_e.tag == tag_of(upd_pc_i);
  always_comb begin
    wr_d = upd_valid_i && (up_hit || upd_taken_i);
    ent_d = up_hit
      ? btb_entry_t'{valid: 1'b1, tag: up_e.tag,
                     target: upd_taken_i ? upd_target_i : up_e.target,
                     counter: bcnt_step(up_e.counter, upd_taken_i)}
      : btb_entry_t'{valid: 1'b1, tag: tag_of(upd_pc_i), target: upd_target_i, counter: BCNT_ALLOC};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= btb_entry_t'{valid: 1'b0, tag: '0, target: '0, counter: BCNT_RST};
    end else if (wr_d) begin
      mem_q[u_idx] <= ent_d;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC register with BTB-based next-PC prediction and redirect counting.
//   CLK, nRST                      clock, async active-low reset
//   ihit, stall                    icache hit and pipeline hold
//   imemaddr, pc_4                 current fetch PC and PC+4
//   pred_taken, pred_target        BTB prediction for imemaddr
//   redirect_valid, redirect_pc    corrective next PC from later stages
//   resolve_*                      resolved branch info for BTB training
//   mispredict_cnt                 saturating count of redirects
module pc_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h00000000,
  parameter int BTB_DEPTH = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  stall,
  output word_t imemaddr,
  output word_t pc_4,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  input  logic  resolve_valid,
  input  word_t resolve_pc,
  input  logic  resolve_taken,
  input  word_t resolve_target,
  output word_t mispredict_cnt
);
  word_t pc_q, pc_d, cnt_q, cnt_d, btb_tgt;
  btb #(.DEPTH(BTB_DEPTH)) u_btb (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .lookup_pc_i (pc_q),
    .hit_o       (pred_taken),
    .target_o    (btb_tgt),
    .upd_valid_i (resolve_valid),
    .upd_pc_i    (resolve_pc),
    .upd_taken_i (resolve_taken),
    .upd_target_i(resolve_target)
  );
  assign imemaddr = pc_q;
  assign pc_4 = pc_q + 32'd4;
  assign pred_target = pred_taken ? btb_tgt : pc_4;
  assign mispredict_cnt = cnt_q;
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : stall ? pc_q : ihit ? pred_target : pc_q;
    cnt_d = (redirect_valid && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q <= PC_INIT;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;
  logic CLK, nRST, ihit, stall, pred_taken;
  logic redirect_valid, resolve_valid, resolve_taken;
  logic [31:0] imemaddr, pc_4, pred_target, redirect_pc, resolve_pc, resolve_target, mispredict_cnt;
  int checks = 0, errors = 0;
  bit m_valid [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int m_ctr [16];
  logic [31:0] m_pc, m_cnt;

  pc_fetch_unit #(.PC_INIT(32'h0), .BTB_DEPTH(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall),
    .imemaddr(imemaddr), .pc_4(pc_4), .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .mispredict_cnt(mispredict_cnt)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic bit m_pred(logic [31:0] pc);
    int i = int'(pc[5:2]);
    return m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2;
  endfunction

  function automatic logic [31:0] m_ptgt(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[int'(pc[5:2])] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 0;
    m_cnt = 0;
  endtask

  task automatic idle();
    ihit = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    resolve_valid = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
  endtask

  // advance model and DUT one clock with the currently driven inputs
  task automatic tick();
    logic [31:0] nxt;
    int j;
    nxt = redirect_valid ? redirect_pc : stall ? m_pc : ihit ? m_ptgt(m_pc) : m_pc;
    if (resolve_valid) begin
      j = int'(resolve_pc[5:2]);
      if (m_valid[j] && m_tag[j] == (resolve_pc >> 6)) begin
        if (resolve_taken) begin
          m_ctr[j] = m_ctr[j] < 3 ? m_ctr[j] + 1 : 3;
          m_tgt[j] = resolve_target;
        end else m_ctr[j] = m_ctr[j] > 0 ? m_ctr[j] - 1 : 0;
      end else if (resolve_taken) begin
        m_valid[j] = 1; m_tag[j] = resolve_pc >> 6; m_tgt[j] = resolve_target; m_ctr[j] = 2;
      end
    end
    if (redirect_valid && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
    @(posedge CLK);
    #1;
    m_pc = nxt;
  endtask

  task automatic redirect_to(logic [31:0] pc);
    idle();
    redirect_valid = 1; redirect_pc = pc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    nRST = 0;
    m_reset();
    #3;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", imemaddr, 32'h0); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h4) begin errors++; $display("FAIL reset_ptgt got %h exp 4", pred_target); end
    checks++; if (mispredict_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", mispredict_cnt); end
    #9 nRST = 1;
  endtask

  task automatic test_sequential();
    idle();
    ihit = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (imemaddr !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", k, imemaddr, 32'(4 * k)); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL seq_pred%0d got %b exp 0", k, pred_taken); end
    end
    idle();
  endtask

  task automatic test_alloc();
    resolve_valid = 1; resolve_pc = 32'h10; resolve_taken = 1; resolve_target = 32'h40;
    tick();
    idle();
    ihit = 1;
    tick();
    checks++; if (imemaddr !== 32'h10) begin errors++; $display("FAIL alloc_pc got %h exp 10", imemaddr); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred got %b exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h40) begin errors++; $display("FAIL alloc_ptgt got %h exp 40", pred_target); end
    tick();
    checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL alloc_jump got %h exp 40", imemaddr); end
    idle();
  endtask

  task automatic test_counter_decay();
    stall = 1; ihit = 1;
    resolve_valid = 1; resolve_pc = 32'h10; resolve_taken = 0; resolve_target = 32'h999;
    tick();
    tick();
    checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL decay_hold got %h exp 40", imemaddr); end
    redirect_to(32'h10);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL decay_pred got %b exp 0", pred_taken); end
    ihit = 1;
    tick();
    checks++; if (imemaddr !== 32'h14) begin errors++; $display("FAIL decay_next got %h exp 14", imemaddr); end
    idle();
  endtask

  task automatic test_redirect_priority();
    logic [31:0] exp_cnt;
    exp_cnt = m_cnt + 1;
    stall = 1; ihit = 1; redirect_valid = 1; redirect_pc = 32'h200;
    tick();
    idle();
    checks++; if (imemaddr !== 32'h200) begin errors++; $display("FAIL prio_pc got %h exp 200", imemaddr); end
    checks++; if (mispredict_cnt !== exp_cnt) begin errors++; $display("FAIL prio_cnt got %0d exp %0d", mispredict_cnt, exp_cnt); end
  endtask

  task automatic test_alias();
    resolve_valid = 1; resolve_pc = 32'h10; resolve_taken = 1; resolve_target = 32'h100;
    repeat (3) tick();
    idle();
    redirect_to(32'h10);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin errors++; $display("FAIL alias_train got %b/%h exp 1/100", pred_taken, pred_target); end
    resolve_valid = 1; resolve_pc = 32'h50; resolve_taken = 1; resolve_target = 32'h300;
    tick();
    redirect_to(32'h10);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got %b exp 0", pred_taken); end
    redirect_to(32'h53);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL alias_new got %b/%h exp 1/300", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    redirect_to(32'h80);
    ihit = 1;
    resolve_valid = 1; resolve_pc = 32'h80; resolve_taken = 1; resolve_target = 32'h500;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_pre got %b exp 0", pred_taken); end
    tick();
    checks++; if (imemaddr !== 32'h84) begin errors++; $display("FAIL same_next got %h exp 84", imemaddr); end
    redirect_to(32'h80);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_post got %b exp 1", pred_taken); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFFFFFC);
    checks++; if (pc_4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_4); end
    ihit = 1;
    tick();
    idle();
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", imemaddr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ihit = ($urandom % 4) != 0;
      stall = ($urandom % 5) == 0;
      redirect_valid = ($urandom % 8) == 0;
      redirect_pc = $urandom & 32'h3FF;
      resolve_valid = $urandom % 2;
      resolve_pc = $urandom & 32'h3FF;
      resolve_taken = $urandom % 2;
      resolve_target = $urandom & 32'hFFC;
      tick();
      checks++;
      if (imemaddr !== m_pc || pc_4 !== m_pc + 32'd4 || pred_taken !== m_pred(m_pc) ||
          pred_target !== m_ptgt(m_pc) || mispredict_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand%0d got pc=%h p4=%h pt=%b tg=%h cnt=%0d exp pc=%h p4=%h pt=%b tg=%h cnt=%0d",
                 n, imemaddr, pc_4, pred_taken, pred_target, mispredict_cnt,
                 m_pc, m_pc + 32'd4, m_pred(m_pc), m_ptgt(m_pc), m_cnt);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [6] = '{32'h10, 32'h50, 32'h80, 32'h20, 32'h30, 32'h300};
    resolve_valid = 1; resolve_pc = 32'h20; resolve_taken = 1; resolve_target = 32'h60;
    tick();
    redirect_valid = 1; redirect_pc = 32'h300;
    resolve_pc = 32'h30; resolve_target = 32'h70;
    #3;
    nRST = 0;
    m_reset();
    #1;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h exp 0", imemaddr); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h4) begin errors++; $display("FAIL rmid_pred got %b/%h exp 0/4", pred_taken, pred_target); end
    checks++; if (mispredict_cnt !== 32'h0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", mispredict_cnt); end
    @(posedge CLK);
    #1;
    idle();
    nRST = 1;
    #1;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL rmid_rel got %h exp 0", imemaddr); end
    ihit = 1;
    tick();
    checks++; if (imemaddr !== 32'h4) begin errors++; $display("FAIL rmid_fetch got %h exp 4", imemaddr); end
    foreach (pcs[k]) begin
      redirect_to(pcs[k]);
      checks++; if (pred_taken !== 1'b0 || m_pred(pcs[k])) begin errors++; $display("FAIL rmid_miss%0d got %b exp 0", k, pred_taken); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_alloc();
    test_counter_decay();
    test_redirect_priority();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, meaning PC value loaded on reset.
REQ-002 Parameter BTB_DEPTH, default 16, meaning number of branch-target-buffer entries; power of two, 2..256.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset; asynchronous, active-low.
REQ-005 ihit  input  1  instruction cache returned the word at imemaddr this cycle.
REQ-006 stall  input  1  pipeline hold request (load-use hazard or outstanding data access).
REQ-007 imemaddr  output  32  current fetch PC.
REQ-008 pc_4  output  32  imemaddr + 4, passed into the fetch/decode pipeline register.
REQ-009 pred_taken  output  1  BTB predicts the instruction at imemaddr is a taken branch or jump.
REQ-010 pred_target  output  32  predicted target; equals pc_4 when pred_taken=0.
REQ-011 redirect_valid  input  1  later stage detected a mispredict or resolved a jump/JR.
REQ-012 redirect_pc  input  32  correct next fetch PC when redirect_valid=1.
REQ-013 resolve_valid  input  1  a control-transfer instruction resolved this cycle; BTB update request.
REQ-014 resolve_pc  input  32  PC of the resolving instruction.
REQ-015 resolve_taken  input  1  actual direction of the resolving instruction.
REQ-016 resolve_target  input  32  actual target of the resolving instruction.
REQ-017 mispredict_cnt  output  32  number of accepted redirects since reset.

Function
REQ-018 imemaddr shall be the PC register directly, with no combinational path from inputs.
REQ-019 pc_4 shall equal imemaddr + 4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-020 BTB entry fields: valid, tag = pc[31:IDX+2], target[31:0], 2-bit saturating counter; IDX = log2(BTB_DEPTH); index = pc[IDX+1:2].
REQ-021 Lookup shall be combinational on imemaddr: pred_taken = valid & tag match & counter[1].
REQ-022 Next-PC priority at each edge: redirect_valid -> redirect_pc; else stall -> hold; else ihit -> (pred_taken ? pred_target : pc_4); else hold.
REQ-023 redirect_valid shall take effect on the next edge regardless of ihit and stall.
REQ-024 On resolve_valid with index hit and tag match: counter increments (saturating at 2'b11) if taken, decrements (saturating at 2'b00) if not; target rewritten only when taken.
REQ-025 On resolve_valid with miss and resolve_taken=1: allocate entry (valid=1, new tag, target, counter=2'b10), replacing any occupant.
REQ-026 On resolve_valid with miss and resolve_taken=0: no BTB change.
REQ-027 Same-cycle lookup and update to the same index: lookup returns pre-update contents; update visible from the next cycle.
REQ-028 BTB update shall occur independently of stall, ihit and redirect_valid.
REQ-029 mispredict_cnt shall increment by 1 per edge with redirect_valid=1 and saturate at 32'hFFFFFFFF.
REQ-030 Low bits resolve_pc[1:0] and redirect_pc[1:0] shall be ignored for indexing; redirect_pc is loaded as given.

Reset
REQ-031 nRST low shall immediately force PC=PC_INIT, all BTB valid=0, all counters=2'b01, mispredict_cnt=0.
REQ-032 During reset pred_taken=0, pred_target=PC_INIT+4, imemaddr=PC_INIT.
REQ-033 Reset asserted mid-operation shall discard pending redirect and update requests; first fetch after release is PC_INIT.

Structure
REQ-034 btb_entry_t (valid, tag, target, counter) and the 2-bit counter type shall be added to cpu_types_pkg; word_t shall be reused for all 32-bit ports.
REQ-035 BTB storage, lookup and update shall be a sub-module named btb, parametrised by BTB_DEPTH; PC register, next-PC mux and counter stay in pc_fetch_unit.

Verification
REQ-036 Reset then ihit=1 for 3 cycles, BTB empty -> imemaddr 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
REQ-037 resolve_valid, resolve_pc=0x10, taken=1, target=0x40; later fetch reaches 0x10 with ihit=1 -> pred_taken=1, next imemaddr=0x40.
REQ-038 Entry at 0x10 counter 2'b10, two not-taken resolves -> counter 2'b00, pred_taken=0 at 0x10, next PC 0x14.
REQ-039 stall=1, ihit=1, redirect_valid=1, redirect_pc=0x200 same cycle -> imemaddr=0x200 next cycle, mispredict_cnt increments by 1.
REQ-040 BTB_DEPTH=16: allocate 0x10 then 0x50 (same index, different tag) -> 0x10 lookup misses, 0x50 hits.
REQ-041 nRST asserted mid-run with BTB populated -> imemaddr=PC_INIT immediately, all lookups miss after release.
